shift_collector: RTL
====================

SHIFT_COLLECTOR -- requirements
Module: shift_collector

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the assembled word width in bits.
REQ-002 Parameter DEPTH, default 4, SHALL set the output FIFO depth in words (power of two, >= 2).
REQ-003 Parameter MSB_FIRST, default 1, SHALL select the bit order: 1 means the first received bit lands in bit WIDTH-1; 0 means it lands in bit 0.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 shift_in  input  1  SHALL carry the serial bit from the upstream shift register's shift_output.
REQ-007 shift_valid  input  1  SHALL qualify shift_in; one bit is consumed per clk edge while high.
REQ-008 frame_clear  input  1  SHALL abort the partially assembled word.
REQ-009 out_data  output  WIDTH  SHALL present the FIFO head word.
REQ-010 out_valid  output  1  SHALL be high whenever the FIFO is non-empty.
REQ-011 out_ready  input  1  SHALL be the consumer accept; a pop occurs on an edge where out_valid && out_ready.
REQ-012 bit_count  output  clog2(WIDTH)  SHALL show the number of bits collected in the current partial word.
REQ-013 fifo_level  output  clog2(DEPTH)+1  SHALL show the FIFO occupancy, 0..DEPTH.
REQ-014 overflow  output  1  SHALL be a sticky flag indicating that a completed word was dropped.
REQ-015 overflow_clr  input  1  SHALL clear overflow.

Function
REQ-016 On an edge with shift_valid=1 and frame_clear=0, the block SHALL insert shift_in into the assembly register per MSB_FIRST and increment bit_count.
REQ-017 When the WIDTH-th bit is consumed, the block SHALL push the completed word into the FIFO on that same edge and return bit_count to 0, wrapping with no idle cycle.
REQ-018 Latency: for a word completing at edge N into an empty FIFO, out_valid=1 and out_data SHALL hold the word after edge N.
REQ-019 out_data and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 If the FIFO is full at completion and no pop occurs on the same edge, the word SHALL be dropped, overflow SHALL set, and FIFO contents SHALL be unchanged.
REQ-021 Simultaneous push and pop SHALL both take effect at any level, including full; fifo_level is unchanged.
REQ-022 A pop from an empty FIFO (out_valid=0) SHALL be ignored.
REQ-023 frame_clear SHALL take priority over shift_valid on the same edge: bit_count goes to 0, the assembly register goes to 0, the bit is discarded, and FIFO state is untouched.
REQ-024 If overflow_clr and a new overflow event occur on the same edge, overflow SHALL end set.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by fifo_level.

Reset
REQ-026 While reset=1, the block SHALL drive out_data=0, out_valid=0, bit_count=0, fifo_level=0, overflow=0, and clear the assembly register, regardless of clk.
REQ-027 Reset asserted mid-word or mid-handshake SHALL discard all partial and buffered data; the first edge after deassertion SHALL behave as bit 0 of a new word.

Structure
REQ-028 Package shift_pkg SHALL hold the WIDTH default constant (8), the DEPTH default (4), and the bit-order constants shared with the upstream shift register.
REQ-029 The FIFO SHALL be a sub-module named shift_fifo (synchronous, first-word-fall-through, level output); assembly logic stays in shift_collector.

Verification
REQ-030 MSB_FIRST=1: shift in bits 1,0,1,1,0,0,1,0 on consecutive edges, out_ready=1 -> out_data=8'hB2, out_valid high exactly one cycle after the 8th edge.
REQ-031 MSB_FIRST=0: the same bit sequence -> out_data=8'h4D.
REQ-032 out_ready=0: push 5 words 8'h01..8'h05 -> fifo_level=4, overflow=1, and a later drain yields 01,02,03,04 only.
REQ-033 3 bits in, then frame_clear together with shift_valid -> bit_count=0; the next 8 bits of 8'hFF -> out_data=8'hFF, with no stale bits.
REQ-034 FIFO full, with the 8th bit and a pop on the same edge -> no overflow, fifo_level stays 4, and the new word is last in order.
REQ-035 Assert reset after 5 bits with 2 words buffered -> all outputs 0 immediately; after release, 8 fresh bits of 8'hA5 -> out_data=8'hA5.

Source files
------------

// File: rtl/shift_pkg.sv
// Constants shared by the serial collector, its output FIFO and the upstream shift register.
package shift_pkg;

    localparam int WIDTH_DEFAULT = 8;
    localparam int DEPTH_DEFAULT = 4;

    typedef enum logic {
        ORDER_LSB_FIRST = 1'b0,
        ORDER_MSB_FIRST = 1'b1
    } bit_order_e;

endpackage

// File: rtl/shift_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy output.
// A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
module shift_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             pop_s;
    logic             push_s;

    assign pop_s   = pop_i && (level_q != {LW{1'b0}});
    assign push_s  = push_i && ((level_q != LW'(DEPTH)) || pop_s);
    assign valid_o = (level_q != {LW{1'b0}});
    assign level_o = level_q;

    // Head word, forced to zero while empty so reset shows a clean bus.
    always_comb begin
        data_o = {WIDTH{1'b0}};
        if (level_q != {LW{1'b0}}) begin
            data_o = mem_q[rd_ptr_q];
        end else begin
            data_o = {WIDTH{1'b0}};
        end
    end

    // Storage array; contents are only observable through the occupancy-gated head.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy tracking; pointers wrap modulo DEPTH.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            level_q  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/shift_collector.sv
// Assembles serial bits into WIDTH-bit words and queues them in a small FIFO.
// Completed words arriving at a full FIFO with no concurrent pop are dropped and flagged.
module shift_collector
    import shift_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter int DEPTH     = DEPTH_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       shift_in,
    input  logic                       shift_valid,
    input  logic                       frame_clear,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(WIDTH)-1:0]   bit_count,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow,
    input  logic                       overflow_clr
);

    localparam int         CW    = $clog2(WIDTH);
    localparam bit_order_e ORDER = bit_order_e'(MSB_FIRST);

    logic [WIDTH-1:0] asm_q;
    logic [WIDTH-1:0] asm_d;
    logic [CW-1:0]    bit_count_q;
    logic [CW-1:0]    bit_count_d;
    logic             overflow_q;
    logic             overflow_d;
    logic [WIDTH-1:0] word_s;
    logic             push_s;
    logic             pop_s;
    logic             drop_s;

    function automatic logic [WIDTH-1:0] insert_bit(input logic [WIDTH-1:0] w, input logic b);
        if (ORDER == ORDER_MSB_FIRST) begin
            return {w[WIDTH-2:0], b};
        end else begin
            return {b, w[WIDTH-1:1]};
        end
    endfunction

    // Bit assembly; frame_clear wins over a concurrent valid bit.
    always_comb begin
        asm_d       = asm_q;
        bit_count_d = bit_count_q;
        push_s      = 1'b0;
        word_s      = insert_bit(asm_q, shift_in);
        if (frame_clear) begin
            asm_d       = {WIDTH{1'b0}};
            bit_count_d = {CW{1'b0}};
        end else if (shift_valid) begin
            if (bit_count_q == CW'(WIDTH - 1)) begin
                push_s      = 1'b1;
                asm_d       = {WIDTH{1'b0}};
                bit_count_d = {CW{1'b0}};
            end else begin
                asm_d       = word_s;
                bit_count_d = bit_count_q + CW'(1);
            end
        end else begin
            asm_d       = asm_q;
            bit_count_d = bit_count_q;
        end
    end

    assign pop_s  = out_valid && out_ready;
    assign drop_s = push_s && (fifo_level == ($clog2(DEPTH) + 1)'(DEPTH)) && !pop_s;

    // Sticky overflow; a new drop outranks a simultaneous clear.
    always_comb begin
        overflow_d = overflow_q;
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Collector state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_q       <= {WIDTH{1'b0}};
            bit_count_q <= {CW{1'b0}};
            overflow_q  <= 1'b0;
        end else begin
            asm_q       <= asm_d;
            bit_count_q <= bit_count_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bit_count = bit_count_q;
    assign overflow  = overflow_q;

    shift_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push_s),
        .data_i  (word_s),
        .pop_i   (pop_s),
        .data_o  (out_data),
        .valid_o (out_valid),
        .level_o (fifo_level)
    );

endmodule
